// File: rtl/reg_file_pkg.sv
// Shared constants and the read-forwarding source selector for the multi-port register file.
package reg_file_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 6;

    // Read data source encoding: stored entry, write port 0 bypass, write port 1 bypass.
    localparam logic [1:0] SEL_STORED = 2'd0;
    localparam logic [1:0] SEL_WP0    = 2'd1;
    localparam logic [1:0] SEL_WP1    = 2'd2;

    // Write port 1 has priority, matching the storage update order.
    function automatic logic [1:0] fwd_sel(input logic hit0, input logic hit1);
        if (hit1) begin
            return SEL_WP1;
        end else if (hit0) begin
            return SEL_WP0;
        end
        return SEL_STORED;
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: write-first forwarding mux, zero-address mask and output flops.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] stored,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam logic ZERO_EN = (ZERO_REG != 0);

    logic [1:0]        sel;
    logic [DATA_W-1:0] fwd_data;

    // Select the value the entry will hold after this edge; address 0 masked when hardwired.
    always_comb begin
        sel = fwd_sel(we0 && (waddr0 == rd_addr), we1 && (waddr1 == rd_addr));
        case (sel)
            SEL_WP1: fwd_data = wdata1;
            SEL_WP0: fwd_data = wdata0;
            default: fwd_data = stored;
        endcase
        if (ZERO_EN && (rd_addr == '0)) begin
            fwd_data = {DATA_W{1'b0}};
        end
    end

    // Capture on request; data holds when idle, valid pulses for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= {DATA_W{1'b0}};
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= fwd_data;
            end
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports (port 1 wins), NUM_RD registered read ports.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic                     wr_collide
);

    localparam int unsigned DEPTH   = 2 ** ADDR_W;
    localparam logic        ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] stored [NUM_RD];
    logic              wr0_eff;
    logic              wr1_eff;
    logic              same_addr;

    // Writes to a hardwired zero entry are dropped before they reach storage or forwarding.
    always_comb begin
        wr0_eff   = we0 && !(ZERO_EN && (waddr0 == '0));
        wr1_eff   = we1 && !(ZERO_EN && (waddr1 == '0));
        same_addr = (waddr0 == waddr1);
    end

    // Storage update; on an address clash only port 1 writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (wr0_eff && !(wr1_eff && same_addr)) begin
                mem[waddr0] <= wdata0;
            end
            if (wr1_eff) begin
                mem[waddr1] <= wdata1;
            end
        end
    end

    // Registered collision flag for effective (non-discarded) writes only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_collide <= 1'b0;
        end else begin
            wr_collide <= wr0_eff && wr1_eff && same_addr;
        end
    end

    // Stored-entry lookup for each read port.
    always_comb begin
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            stored[k] = mem[rd_addr[k*ADDR_W +: ADDR_W]];
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        reg_file_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .clk      (clk),
            .rst      (rst),
            .rd_en    (rd_en[k]),
            .rd_addr  (rd_addr[k*ADDR_W +: ADDR_W]),
            .stored   (stored[k]),
            .we0      (wr0_eff),
            .waddr0   (waddr0),
            .wdata0   (wdata0),
            .we1      (wr1_eff),
            .waddr1   (waddr1),
            .wdata1   (wdata1),
            .rd_data  (rd_data[k*DATA_W +: DATA_W]),
            .rd_valid (rd_valid[k])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: driver pushes expected responses, monitor pops and compares.
module tb_reg_file_mp;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned NUM_RD = 2;
    localparam int unsigned DEPTH  = 64;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     we0 = 1'b0;
    logic [ADDR_W-1:0]        waddr0 = '0;
    logic [DATA_W-1:0]        wdata0 = '0;
    logic                     we1 = 1'b0;
    logic [ADDR_W-1:0]        waddr1 = '0;
    logic [DATA_W-1:0]        wdata1 = '0;
    logic [NUM_RD-1:0]        rd_en = '0;
    logic [NUM_RD*ADDR_W-1:0] rd_addr = '0;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_valid;
    logic                     wr_collide;

    reg_file_mp #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .we0        (we0),
        .waddr0     (waddr0),
        .wdata0     (wdata0),
        .we1        (we1),
        .waddr1     (waddr1),
        .wdata1     (wdata1),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wr_collide (wr_collide)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_RD-1:0]        v;
        logic                     col;
        logic [NUM_RD*DATA_W-1:0] d;
    } exp_t;

    exp_t              cyc_q[$];
    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] hold  [NUM_RD];
    int                n_chk = 0;
    int                n_fail = 0;
    bit                running = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the reference model applies port 0 then port 1, so port 1 wins.
    task automatic step(input logic w0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                        input logic w1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                        input logic [NUM_RD-1:0] en, input logic [NUM_RD*ADDR_W-1:0] ra);
        exp_t e;
        logic [ADDR_W-1:0] a;
        @(negedge clk);
        rst = 1'b0;
        we0 = w0; waddr0 = a0; wdata0 = d0;
        we1 = w1; waddr1 = a1; wdata1 = d1;
        rd_en = en; rd_addr = ra;
        if (w0 && a0 != 0) model[a0] = d0;
        if (w1 && a1 != 0) model[a1] = d1;
        e.v   = en;
        e.col = w0 && w1 && (a0 == a1) && (a0 != 0);
        e.d   = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            a = ra[k*ADDR_W +: ADDR_W];
            e.d[k*DATA_W +: DATA_W] = (a == 0) ? '0 : model[a];
        end
        cyc_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    endtask

    // Async reset one cycle after the last read request; outputs must clear at once.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        rd_en = '1;
        #1;
        chk("reset rd_valid", 64'(rd_valid), 64'd0);
        chk("reset rd_data", 64'(rd_data), 64'd0);
        chk("reset wr_collide", 64'(wr_collide), 64'd0);
        cyc_q.delete();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        @(negedge clk);
        @(negedge clk);
    endtask

    function automatic logic [ADDR_W-1:0] pick_addr();
        return ($urandom % 4 == 0) ? ADDR_W'($urandom % DEPTH) : ADDR_W'($urandom % 8);
    endfunction

    // Monitor: one expected entry per un-reset cycle; rd_data must hold when not valid.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                for (int k = 0; k < NUM_RD; k++) hold[k] = '0;
                continue;
            end
            if (!running) continue;
            if (cyc_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard: got empty queue, expected an entry (t=%0t)", $time);
                continue;
            end
            e = cyc_q.pop_front();
            chk("rd_valid", 64'(rd_valid), 64'(e.v));
            chk("wr_collide", 64'(wr_collide), 64'(e.col));
            for (int k = 0; k < NUM_RD; k++) begin
                if (e.v[k]) hold[k] = e.d[k*DATA_W +: DATA_W];
                chk($sformatf("rd_data[%0d]", k), 64'(rd_data[k*DATA_W +: DATA_W]), 64'(hold[k]));
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int k = 0; k < NUM_RD; k++) hold[k] = '0;
        #1 rst = 1'b1;
        #2;
        chk("power-on rd_valid", 64'(rd_valid), 64'd0);
        chk("power-on rd_data", 64'(rd_data), 64'd0);
        running = 1'b1;

        // All addresses read back zero after reset, on both ports.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, '0, 1'b0, '0, '0, 2'b11, {ADDR_W'(DEPTH - 1 - i), ADDR_W'(i)});
        end
        // Same-cycle write forwarded to the read.
        step(1'b1, 6'd5, 32'hDEADBEEF, 1'b0, '0, '0, 2'b01, {6'd0, 6'd5});
        // Collision on address 9; port 1 wins.
        step(1'b1, 6'd9, 32'h1111, 1'b1, 6'd9, 32'h2222, 2'b00, '0);
        step(1'b0, '0, '0, 1'b0, '0, '0, 2'b11, {6'd9, 6'd9});
        // Writes to the zero register are discarded, even when read the same cycle.
        step(1'b0, '0, '0, 1'b1, 6'd0, 32'hFFFFFFFF, 2'b10, {6'd0, 6'd3});
        step(1'b1, 6'd0, 32'h1234, 1'b1, 6'd0, 32'h5678, 2'b11, {6'd0, 6'd0});
        step(1'b0, '0, '0, 1'b0, '0, '0, 2'b11, {6'd0, 6'd0});
        // Read 12, then hold while 12 is rewritten.
        step(1'b1, 6'd12, 32'hAAAA5555, 1'b0, '0, '0, 2'b00, '0);
        step(1'b0, '0, '0, 1'b0, '0, '0, 2'b11, {6'd12, 6'd12});
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 6'd12, $urandom, 1'b1, 6'd12, $urandom, 2'b00, {6'd12, 6'd12});
        end
        step(1'b0, '0, '0, 1'b0, '0, '0, 2'b11, {6'd12, 6'd12});

        // Randomized traffic, biased to low addresses for forwarding and collisions.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), pick_addr(), $urandom, 1'($urandom), pick_addr(), $urandom,
                 NUM_RD'($urandom), {pick_addr(), pick_addr()});
        end

        // Mid-stream reset with a read in flight.
        step(1'b1, 6'd20, 32'hCAFEF00D, 1'b0, '0, '0, 2'b00, '0);
        step(1'b0, '0, '0, 1'b0, '0, '0, 2'b11, {6'd20, 6'd5});
        do_reset();
        idle();
        step(1'b0, '0, '0, 1'b0, '0, '0, 2'b11, {6'd20, 6'd5});
        step(1'b0, '0, '0, 1'b0, '0, '0, 2'b11, {6'd9, 6'd12});
        idle();

        @(posedge clk);
        #2;
        running = 1'b0;
        chk("scoreboard drained", 64'(cyc_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
